hazard_sequencer: RTL and testbench
===================================

# hazard_sequencer

Pipeline hazard controller for the 5-stage datapath. It watches the branch/jump resolution signals, load-use dependencies, memory completion and halt. From these it drives the per-latch enable/flush controls, the PC enable and the `flushed` indication consumed through the hazard unit interface `pipe` modport. A small state machine handles data-memory wait, halt drain and a memory-wait watchdog.

## Interface
- `REGW`, 5, register address width
- `TIMEOUT`, 1024, MEMWAIT cycles before `mem_timeout` sets (≥2)
- `CLK` in 1, system clock, rising edge
- `nRST` in 1, synchronous active-low reset
- `ihit` in 1, instruction fetch complete this cycle
- `dhit` in 1, data access complete this cycle
- `mem_dreq` in 1, instruction in EX/MEM has dREN or dWEN
- `ex_load` in 1, instruction in ID/EX is a load
- `ex_rd` in `REGW`, destination register of ID/EX instruction
- `id_rs`, `id_rt` in `REGW`, source registers of IF/ID instruction
- `id_uses_rt` in 1, IF/ID instruction reads rt
- `PCsrc` in 3, EX-stage next-PC select
- `zero` in 1, EX-stage ALU zero flag
- `wb_halt` in 1, halt instruction in MEM/WB
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en`, `memwb_en` out 1, latch enables
- `ifid_flush`, `idex_flush`, `exmem_flush` out 1, synchronous latch clears, qualified by the matching enable
- `flushed` out 1, registered pulse: a redirect flush was committed last cycle
- `halted` out 1, sticky halt
- `mem_timeout` out 1, sticky watchdog flag

## Operation
- PCsrc encoding: 0 sequential; 1 BEQ (taken iff `zero`); 2 BNE (taken iff `!zero`); 3 J; 4 JAL; 5 JR; 6–7 treated as sequential.
- `redirect` is 1 for PCsrc 3/4/5, PCsrc 1 with `zero`, or PCsrc 2 with `!zero`.
- `loaduse` = `ex_load` && `ex_rd` != 0 && (`ex_rd`==`id_rs` || (`id_uses_rt` && `ex_rd`==`id_rt`)).
- `memstall` = `mem_dreq` && !`dhit`.
- States: RUN, MEMWAIT, HALTED.
- RUN, evaluated in priority order, first match wins:
  1. `memstall`: all enables 0; next state MEMWAIT.
  2. `redirect`: `pc_en` = `ihit`. `ifid_en`/`idex_en`/`exmem_en`/`memwb_en` = 1. `ifid_flush` = `idex_flush` = 1. Redirect beats `loaduse`, because the ID instruction is wrong-path.
  3. `loaduse`: `pc_en` = `ifid_en` = 0; `idex_en` = 1 with `idex_flush` (bubble); EX/MEM and MEM/WB advance.
  4. Otherwise: `pc_en` = `ifid_en` = `ihit`. If !`ihit`, IF/ID inserts a bubble (`ifid_en`=1, `ifid_flush`=1) and downstream latches advance.
- MEMWAIT: all enables 0; the wait counter increments. On `dhit`, the pipeline advances exactly as RUN rule 2/3/4 this cycle, and the next state is RUN.
- `mem_timeout` sets when the wait counter reaches `TIMEOUT`-1. It remains set while in MEMWAIT. It is cleared only by reset.
- `wb_halt` while RUN and !`memstall`: the current cycle completes its WB. Next state is HALTED.
- HALTED: all enables 0, all flushes 0, `halted`=1. Holds until reset. All other inputs are ignored.
- `flushed` ← 1 on any cycle where `ifid_flush` was driven by rule 2 with `idex_en`=1; otherwise ← 0.
- `exmem_flush` is driven only under `STATS_RESET`-free normal operation as 0 (reserved; it is always 0).

## Timing
- Enables and flushes are combinational from inputs and state (same-cycle).
- `flushed`, `halted`, `mem_timeout`, the state and the wait counter are registered.
- Reset (`nRST`=0 at CLK edge): state RUN, wait counter 0, `flushed`=0, `halted`=0, `mem_timeout`=0, and counters 0 (if compiled in).
- While `nRST`=0, all enables and flushes are forced 0.
- Reset during MEMWAIT or HALTED returns to RUN on the next edge. No pending redirect is retained.
- Redirect latency: the flush applies in the same cycle that PCsrc is valid in EX. `flushed` rises 1 cycle later, for 1 cycle.
- Load-use bubble costs exactly 1 cycle. The next cycle re-evaluates with the load in MEM, so there is no repeat.
- The wait counter saturates at `TIMEOUT`-1 and is cleared on entry to RUN.
- A simultaneous `dhit` and `redirect` in MEMWAIT flushes on that cycle.

## Configuration
- `HAZARD_STATS_EN` defined adds output ports `stall_cnt` (out, 32) and `flush_cnt` (out, 32).
  - `stall_cnt` increments on every cycle where `pc_en`=0 and the state is not HALTED.
  - `flush_cnt` increments on every `flushed` pulse.
  - Both wrap at 2^32 and reset to 0.
- `HAZARD_STATS_EN` undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Test plan
- BEQ, `PCsrc`=1, `zero`=1, `ihit`=1 → `ifid_flush`=`idex_flush`=1, `pc_en`=1; `flushed`=1 next cycle only. Same stimulus with `zero`=0 → no flush.
- `ex_load`=1, `ex_rd`=8, `id_rs`=8 → 1 cycle with `pc_en`=`ifid_en`=0 and `idex_flush`=1; the following cycle is normal. Same stimulus with `ex_rd`=0 → no stall.
- `mem_dreq`=1, `dhit`=0 for 5 cycles then 1 → all enables 0 for 5 cycles; on the `dhit` cycle all enables 1; state returns to RUN.
- `TIMEOUT`=4, `dhit` held 0 for 6 cycles → `mem_timeout` rises after the 4th MEMWAIT cycle and stays 1 through a later `dhit`; clears only on `nRST`=0.
- `PCsrc`=3 together with a load-use match → redirect flush wins: `idex_flush`=1, `ifid_flush`=1, `pc_en`=1; no stall cycle.
- `wb_halt`=1 → `halted`=1 next cycle with all enables 0. Later `ihit`/`PCsrc` activity is ignored; `nRST`=0 clears it. With `HAZARD_STATS_EN`, check `stall_cnt`/`flush_cnt` against the counts from the above scenarios.

Source files
------------

// File: rtl/hazard_sequencer_if.sv
// Hazard unit interface: pipeline status toward the hazard controller, latch controls back.
// The datapath connects via master (alias pipe); the controller via slave.
interface hazard_sequencer_if #(
  parameter int REGW = 5
);
  logic            ihit;
  logic            dhit;
  logic            mem_dreq;
  logic            ex_load;
  logic [REGW-1:0] ex_rd;
  logic [REGW-1:0] id_rs;
  logic [REGW-1:0] id_rt;
  logic            id_uses_rt;
  logic [2:0]      PCsrc;
  logic            zero;
  logic            wb_halt;
  logic            pc_en;
  logic            ifid_en;
  logic            idex_en;
  logic            exmem_en;
  logic            memwb_en;
  logic            ifid_flush;
  logic            idex_flush;
  logic            exmem_flush;
  logic            flushed;
  logic            halted;
  logic            mem_timeout;

  modport master (
    output ihit, dhit, mem_dreq, ex_load, ex_rd, id_rs, id_rt, id_uses_rt, PCsrc, zero, wb_halt,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush,
           flushed, halted, mem_timeout
  );

  modport pipe (
    output ihit, dhit, mem_dreq, ex_load, ex_rd, id_rs, id_rt, id_uses_rt, PCsrc, zero, wb_halt,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush,
           flushed, halted, mem_timeout
  );

  modport slave (
    input  ihit, dhit, mem_dreq, ex_load, ex_rd, id_rs, id_rt, id_uses_rt, PCsrc, zero, wb_halt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush,
           flushed, halted, mem_timeout
  );
endinterface

// File: rtl/hazard_sequencer.sv
// hazard_sequencer: 5-stage pipeline hazard controller (redirect flush, load-use bubble,
// data-memory wait with watchdog, halt drain). Define HAZARD_STATS_EN for stall/flush counters.
module hazard_sequencer #(
  parameter int REGW    = 5,
  parameter int TIMEOUT = 1024
) (
  input  logic              CLK,
  input  logic              nRST,
  hazard_sequencer_if.slave pipe
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] WAIT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    HALTED  = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [CW-1:0] wait_cnt_r;
  logic          flushed_r;
  logic          halted_r;
  logic          mem_timeout_r;
  logic          redirect_s;
  logic          loaduse_s;
  logic          memstall_s;
  logic          advance_s;
  logic          redir_flush_s;
  logic          pc_en_s;
  logic          ifid_en_s;
  logic          idex_en_s;
  logic          ifid_flush_s;
  logic          idex_flush_s;

  // Branch/jump resolution from the EX-stage next-PC select.
  always_comb begin
    redirect_s = 1'b0;
    case (pipe.PCsrc)
      3'd1:             redirect_s = pipe.zero;
      3'd2:             redirect_s = ~pipe.zero;
      3'd3, 3'd4, 3'd5: redirect_s = 1'b1;
      default:          redirect_s = 1'b0;
    endcase
  end

  assign loaduse_s = pipe.ex_load && (pipe.ex_rd != {REGW{1'b0}}) &&
                     ((pipe.ex_rd == pipe.id_rs) || (pipe.id_uses_rt && (pipe.ex_rd == pipe.id_rt)));
  assign memstall_s    = pipe.mem_dreq & ~pipe.dhit;
  assign redir_flush_s = advance_s & redirect_s;

  // Next-state logic; advance_s marks cycles where the pipeline may move.
  always_comb begin
    state_s   = state_r;
    advance_s = 1'b0;
    if (!nRST) begin
      state_s = RUN;
    end else begin
      case (state_r)
        RUN: begin
          if (memstall_s) begin
            state_s = MEMWAIT;
          end else begin
            advance_s = 1'b1;
            state_s   = pipe.wb_halt ? HALTED : RUN;
          end
        end
        MEMWAIT: begin
          if (pipe.dhit) begin
            advance_s = 1'b1;
            state_s   = RUN;
          end else begin
            state_s = MEMWAIT;
          end
        end
        HALTED:  state_s = HALTED;
        default: state_s = RUN;
      endcase
    end
  end

  // Latch enables and flushes; redirect outranks load-use since the ID instruction is wrong-path.
  always_comb begin
    pc_en_s      = 1'b0;
    ifid_en_s    = 1'b0;
    idex_en_s    = 1'b0;
    ifid_flush_s = 1'b0;
    idex_flush_s = 1'b0;
    if (advance_s) begin
      idex_en_s = 1'b1;
      if (redirect_s) begin
        pc_en_s      = pipe.ihit;
        ifid_en_s    = 1'b1;
        ifid_flush_s = 1'b1;
        idex_flush_s = 1'b1;
      end else if (loaduse_s) begin
        idex_flush_s = 1'b1;
      end else begin
        pc_en_s      = pipe.ihit;
        ifid_en_s    = 1'b1;
        ifid_flush_s = ~pipe.ihit;
      end
    end else begin
      pc_en_s = 1'b0;
    end
  end

  assign pipe.pc_en       = pc_en_s;
  assign pipe.ifid_en     = ifid_en_s;
  assign pipe.idex_en     = idex_en_s;
  assign pipe.exmem_en    = advance_s;
  assign pipe.memwb_en    = advance_s;
  assign pipe.ifid_flush  = ifid_flush_s;
  assign pipe.idex_flush  = idex_flush_s;
  assign pipe.exmem_flush = 1'b0;
  assign pipe.flushed     = flushed_r;
  assign pipe.halted      = halted_r;
  assign pipe.mem_timeout = mem_timeout_r;

  // State, saturating wait counter, sticky watchdog and status flags.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_r       <= RUN;
      wait_cnt_r    <= {CW{1'b0}};
      flushed_r     <= 1'b0;
      halted_r      <= 1'b0;
      mem_timeout_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      flushed_r <= redir_flush_s;
      halted_r  <= (state_s == HALTED);
      if ((state_r == MEMWAIT) && (wait_cnt_r == WAIT_MAX)) begin
        mem_timeout_r <= 1'b1;
      end else begin
        mem_timeout_r <= mem_timeout_r;
      end
      if (state_s != MEMWAIT) begin
        wait_cnt_r <= {CW{1'b0}};
      end else if ((state_r == MEMWAIT) && (wait_cnt_r != WAIT_MAX)) begin
        wait_cnt_r <= wait_cnt_r + CW'(1);
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] flush_cnt_r;

  // Performance counters; both wrap naturally at 2^32.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stall_cnt_r <= 32'd0;
      flush_cnt_r <= 32'd0;
    end else begin
      if (!pc_en_s && (state_r != HALTED)) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flushed_r) begin
        flush_cnt_r <= flush_cnt_r + 32'd1;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;
`endif
endmodule

// File: tb/tb_hazard_sequencer.sv
// Scoreboard bench for hazard_sequencer: directed hazard scenarios followed by random
// traffic, each cycle checked against a rule-level reference model.
module tb_hazard_sequencer;
  localparam int REGW    = 5;
  localparam int TIMEOUT = 4;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;

  hazard_sequencer_if #(.REGW(REGW)) hif ();

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  hazard_sequencer #(.REGW(REGW), .TIMEOUT(TIMEOUT)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .pipe      (hif.slave)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit            nrst;
    bit            ihit;
    bit            dhit;
    bit            mem_dreq;
    bit            ex_load;
    bit [REGW-1:0] ex_rd;
    bit [REGW-1:0] id_rs;
    bit [REGW-1:0] id_rt;
    bit            id_uses_rt;
    bit [2:0]      pcsrc;
    bit            zero;
    bit            wb_halt;
  } stim_t;

  // vec = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush,
  //        flushed, halted, mem_timeout}
  typedef struct {
    logic [10:0] vec;
    int unsigned stalls;
    int unsigned flushes;
    string       tag;
  } exp_t;

  exp_t expq[$];
  exp_t me;
  logic [10:0] act;
  int n_cmp = 0;
  int n_err = 0;

  // Reference model: pipeline mode flags plus counts of wait cycles and events.
  bit          m_wait, m_halt, m_flushed, m_timeout;
  int          m_wait_cycles;
  int unsigned m_stalls, m_flushes;

  task automatic model_reset();
    m_wait = 0; m_halt = 0; m_flushed = 0; m_timeout = 0;
    m_wait_cycles = 0; m_stalls = 0; m_flushes = 0;
  endtask

  task automatic model_step(input stim_t s, output exp_t e);
    bit       redirect, loaduse, go, redir_taken;
    bit [4:0] en;
    bit [2:0] fl;
    redirect = (s.pcsrc == 3'd3) || (s.pcsrc == 3'd4) || (s.pcsrc == 3'd5) ||
               (s.pcsrc == 3'd1 && s.zero) || (s.pcsrc == 3'd2 && !s.zero);
    loaduse  = s.ex_load && (s.ex_rd != 0) &&
               ((s.ex_rd == s.id_rs) || (s.id_uses_rt && s.ex_rd == s.id_rt));
    go = s.nrst && !m_halt && (m_wait ? s.dhit : !(s.mem_dreq && !s.dhit));
    en = 5'b0; fl = 3'b0; redir_taken = 0;
    if (go) begin
      if (redirect) begin
        en = {s.ihit, 4'b1111}; fl = 3'b110; redir_taken = 1;
      end else if (loaduse) begin
        en = 5'b00111; fl = 3'b010;
      end else begin
        en = {s.ihit, 4'b1111}; fl = {!s.ihit, 2'b00};
      end
    end
    e.vec     = {en, fl, m_flushed, m_halt, m_timeout};
    e.stalls  = m_stalls;
    e.flushes = m_flushes;
    if (!s.nrst) begin
      model_reset();
    end else begin
      if (!m_halt && !en[4]) m_stalls++;
      if (m_flushed) m_flushes++;
      m_flushed = redir_taken;
      if (m_halt) begin
        m_halt = 1;
      end else if (m_wait) begin
        m_wait_cycles++;
        if (m_wait_cycles >= TIMEOUT) m_timeout = 1;
        if (s.dhit) begin
          m_wait = 0; m_wait_cycles = 0;
        end
      end else if (s.mem_dreq && !s.dhit) begin
        m_wait = 1;
      end else if (s.wb_halt) begin
        m_halt = 1;
      end
    end
  endtask

  task automatic apply(input stim_t s);
    nRST           = s.nrst;
    hif.ihit       = s.ihit;
    hif.dhit       = s.dhit;
    hif.mem_dreq   = s.mem_dreq;
    hif.ex_load    = s.ex_load;
    hif.ex_rd      = s.ex_rd;
    hif.id_rs      = s.id_rs;
    hif.id_rt      = s.id_rt;
    hif.id_uses_rt = s.id_uses_rt;
    hif.PCsrc      = s.pcsrc;
    hif.zero       = s.zero;
    hif.wb_halt    = s.wb_halt;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.nrst = 1; s.ihit = 1; s.dhit = 0; s.mem_dreq = 0; s.ex_load = 0;
    s.ex_rd = 0; s.id_rs = 0; s.id_rt = 0; s.id_uses_rt = 0;
    s.pcsrc = 3'd0; s.zero = 0; s.wb_halt = 0;
    return s;
  endfunction

  task automatic drive(input stim_t s, input string tag);
    exp_t e;
    @(posedge CLK);
    #1;
    apply(s);
    model_step(s, e);
    e.tag = tag;
    expq.push_back(e);
  endtask

  // Monitor: outputs are valid every cycle, compared mid-cycle against the queued expectation.
  always @(negedge CLK) begin
    if (expq.size() > 0) begin
      me  = expq.pop_front();
      act = {hif.pc_en, hif.ifid_en, hif.idex_en, hif.exmem_en, hif.memwb_en,
             hif.ifid_flush, hif.idex_flush, hif.exmem_flush,
             hif.flushed, hif.halted, hif.mem_timeout};
      n_cmp++;
      if (act !== me.vec) begin
        n_err++;
        $display("FAIL %s: outputs got %b expected %b", me.tag, act, me.vec);
      end
`ifdef HAZARD_STATS_EN
      n_cmp++;
      if (stall_cnt !== me.stalls || flush_cnt !== me.flushes) begin
        n_err++;
        $display("FAIL %s_stats: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                 me.tag, stall_cnt, flush_cnt, me.stalls, me.flushes);
      end
`endif
    end
  end

  initial begin
    stim_t s;
    model_reset();
    s = idle();
    s.nrst = 0;
    apply(s);
    repeat (2) @(posedge CLK);

    drive(s, "reset");
    drive(s, "reset_hold");
    s = idle(); drive(s, "normal"); drive(s, "normal2");

    s = idle(); s.pcsrc = 3'd1; s.zero = 1; drive(s, "beq_taken");
    s = idle(); drive(s, "beq_flushed_pulse"); drive(s, "beq_pulse_end");
    s = idle(); s.pcsrc = 3'd1; s.zero = 0; drive(s, "beq_not_taken");
    s = idle(); s.pcsrc = 3'd2; s.zero = 0; drive(s, "bne_taken");
    s = idle(); s.ihit = 0; drive(s, "ifetch_miss");

    s = idle(); s.ex_load = 1; s.ex_rd = 5'd8; s.id_rs = 5'd8; drive(s, "loaduse");
    s = idle(); drive(s, "loaduse_after");
    s = idle(); s.ex_load = 1; s.ex_rd = 5'd0; s.id_rs = 5'd0; drive(s, "loaduse_r0");
    s = idle(); s.ex_load = 1; s.ex_rd = 5'd9; s.id_rt = 5'd9; s.id_uses_rt = 1;
    drive(s, "loaduse_rt");
    s.id_uses_rt = 0; drive(s, "loaduse_rt_unused");

    s = idle(); s.mem_dreq = 1;
    for (int i = 0; i < 5; i++) drive(s, "memwait");
    s.dhit = 1; drive(s, "memwait_dhit");
    s = idle(); drive(s, "memwait_run");
    s.nrst = 0; drive(s, "reset_clear");

    s = idle(); s.mem_dreq = 1;
    for (int i = 0; i < 7; i++) drive(s, "timeout_wait");
    s.dhit = 1; s.pcsrc = 3'd4; drive(s, "timeout_dhit_redirect");
    s = idle(); drive(s, "timeout_sticky"); drive(s, "timeout_sticky2");
    s.nrst = 0; drive(s, "timeout_reset");

    s = idle(); s.pcsrc = 3'd3; s.ex_load = 1; s.ex_rd = 5'd8; s.id_rs = 5'd8;
    drive(s, "jump_beats_loaduse");
    s = idle(); drive(s, "jump_after");

    s = idle(); s.wb_halt = 1; drive(s, "halt");
    for (int i = 0; i < 4; i++) begin
      s = idle(); s.pcsrc = 3'd5; s.ihit = i[0]; s.mem_dreq = i[1]; drive(s, "halted_ignore");
    end
    s = idle(); s.nrst = 0; drive(s, "halt_reset");
    s = idle(); drive(s, "after_halt");

    for (int i = 0; i < 3000; i++) begin
      s.nrst       = ($urandom_range(39) != 0);
      s.ihit       = ($urandom_range(7) != 0);
      s.dhit       = ($urandom_range(2) == 0);
      s.mem_dreq   = ($urandom_range(3) == 0);
      s.ex_load    = ($urandom_range(1) == 0);
      s.ex_rd      = REGW'($urandom_range(3));
      s.id_rs      = REGW'($urandom_range(3));
      s.id_rt      = REGW'($urandom_range(3));
      s.id_uses_rt = ($urandom_range(1) == 0);
      s.pcsrc      = 3'($urandom_range(7));
      s.zero       = ($urandom_range(1) == 0);
      s.wb_halt    = ($urandom_range(199) == 0);
      drive(s, "random");
    end

    for (int i = 0; i < 10 && expq.size() > 0; i++) @(posedge CLK);
    n_cmp++;
    if (expq.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
